imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised instruction memory for the single-cycle RISC-V core. Replaces hard-coded preload with a runtime program-load port and a synchronous fetch port.
- After reset, sequentially clears every word to a NOP, accepts a program over a valid/ready loader interface, then serves registered fetches with alignment and range fault reporting.
- Sits between the PC/fetch stage and the decoder; the loader port is driven by the testbench or a boot block.

Parameters:
- XLEN, 32, instruction word width in bits.
- DEPTH, 64, number of words; power of two, at least 4. Localparam AW = $clog2(DEPTH).
- NOP_WORD, 32'h00000013, fill value for clear and faulted fetches (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; in RUN, re-enter LOAD without clearing.
- load_valid  in  1  loader write request.
- load_ready  out  1  high only in LOAD.
- load_addr  in  AW  word index.
- load_data  in  XLEN  word to write.
- load_done  in  1  pulse; ends LOAD.
- load_err  out  1  sticky; set when an accepted write had an out-of-range index.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  byte address from PC.
- fetch_valid  out  1  registered response strobe.
- instruction_out  out  XLEN  fetched word.
- fetch_fault  out  1  qualifies the current response as faulted.
- fault_cause  out  2  01 = misaligned, 10 = out of range, 00 = none.
- mem_ready  out  1  high in RUN.

Behaviour:
- States: CLEAR, LOAD, RUN. Reset drives the state to CLEAR from any state, including mid-load or mid-fetch.
- Reset values:
  - clr_cnt = 0, load_ready = 0, load_err = 0, mem_ready = 0.
  - fetch_valid = 0, fetch_fault = 0, fault_cause = 00.
  - instruction_out = 0.
- CLEAR:
  - Writes NOP_WORD to word clr_cnt each cycle and increments clr_cnt.
  - After the write to DEPTH-1, goes to LOAD. CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - All loader and fetch inputs are ignored.
- LOAD:
  - load_ready = 1. A write happens on any edge with load_valid high.
  - Index >= DEPTH: write dropped, load_err set. This only occurs if AW is widened externally; the check is kept for DEPTH-1 masks.
  - Later writes to the same index overwrite earlier ones.
  - load_done alone: go to RUN next cycle.
  - load_valid and load_done together: the write is committed, then go to RUN.
  - fetch_req ignored.
- RUN:
  - mem_ready = 1.
  - A fetch_req sampled at edge N produces fetch_valid = 1 for one cycle after edge N. Back-to-back requests give one response per cycle.
  - Index = fetch_addr[AW+1:2].
  - Misaligned (fetch_addr[1:0] != 00): fault_cause = 01.
  - Out of range (fetch_addr[31:AW+2] != 0): fault_cause = 10.
  - Misaligned takes priority when both apply.
  - On a fault: fetch_fault = 1 and instruction_out = NOP_WORD. Otherwise fetch_fault = 0 and instruction_out = mem[index].
  - When fetch_valid = 0, instruction_out holds its last value.
- load_start in RUN: go to LOAD next cycle. A fetch_req in the same cycle is still answered. Memory contents are preserved.
- load_err clears only on rst.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on clear and load writes.
  - On a fetch, a parity mismatch gives fetch_fault = 1, fault_cause = 11, instruction_out = NOP_WORD. Alignment and range faults take priority.
  - A test-only input force_par_flip (1 bit) inverts the stored parity bit on the next load write.
- When undefined: no parity storage, no force_par_flip port, and fault_cause 11 never occurs.

Test Plan:
- Reset and clear: rst for 2 cycles, then release. mem_ready = 0 and load_ready = 0 for 64 cycles, then load_ready = 1. Immediate load_done, then fetch 0x0C returns 0x00000013.
- Load and fetch: write 0x00500093 at index 0 and 0x00A18193 at index 5, then load_done. Fetch 0x00 returns 0x00500093 one cycle later; fetch 0x14 returns 0x00A18193; fetch 0x04 returns NOP.
- Faults: fetch 0x06 gives fault_cause = 01 and NOP. Fetch 0x100 gives fault_cause = 10. Fetch 0x102 gives fault_cause = 01. fetch_valid = 1 in each case.
- Simultaneous events: load_valid + load_done at index 3 = 0xDEADBEEF, then fetch 0x0C returns 0xDEADBEEF. load_start + fetch_req in the same cycle: response delivered, then load_ready = 1 and old contents are retained.
- Reset mid-operation: assert rst during back-to-back fetches. fetch_valid = 0 next cycle, then a 64-cycle clear, and all words read back as NOP.
- With IMEM_PARITY_EN: load index 2 with force_par_flip = 1. Fetch 0x08 gives fetch_fault = 1, fault_cause = 11, NOP.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: clear-to-NOP, valid/ready program load, registered fetch.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   force_par_flip    (IMEM_PARITY_EN only) invert parity of the next load write
//   load_start        pulse in RUN: back to LOAD, contents kept
//   load_valid        loader write request (accepted every edge in LOAD)
//   load_ready        high only in LOAD
//   load_addr         loader word index
//   load_data         loader word
//   load_done         pulse: leave LOAD for RUN
//   load_err          sticky: an accepted write had an out-of-range index
//   fetch_req         fetch request (honoured only in RUN)
//   fetch_addr        byte address from the PC
//   fetch_valid       one-cycle response strobe
//   instruction_out   fetched word, held between responses
//   fetch_fault       current response is faulted
//   fault_cause       01 misaligned, 10 out of range, 11 parity, 00 none
//   mem_ready         high in RUN
module imem_loadable #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef IMEM_PARITY_EN
  input  logic             force_par_flip,
`endif
  input  logic             load_start,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]  load_data,
  input  logic             load_done,
  output logic             load_err,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  instruction_out,
  output logic             fetch_fault,
  output logic [1:0]       fault_cause,
  output logic             mem_ready
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_OOR  = 2'b10;
  localparam logic [1:0] C_PAR  = 2'b11;

  // ------------------------------------------------------------
  // State
  // ------------------------------------------------------------
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic            r_load_err;
  logic            r_fetch_valid;
  logic            r_fetch_fault;
  logic [1:0]      r_fault_cause;
  logic [XLEN-1:0] r_instr;

  logic [XLEN-1:0] r_mem [DEPTH];

  logic w_in_clear;
  logic w_in_load;
  logic w_in_run;

  assign w_in_clear = (r_state == S_CLEAR);
  assign w_in_load  = (r_state == S_LOAD);
  assign w_in_run   = (r_state == S_RUN);

  // ------------------------------------------------------------
  // Write port: clear sweep or loader, never both
  // ------------------------------------------------------------
  logic            w_clr_last;
  logic            w_load_oob;
  logic            w_load_wr;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [XLEN-1:0] w_mem_wdata;

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  // Unreachable with an AW-wide index; kept so a widened
  // loader address still drops stray writes safely.
  assign w_load_oob = (32'(load_addr) >= 32'(DEPTH));

  assign w_load_wr  = w_in_load & load_valid & ~w_load_oob;

  // Gated by rst so a reset landing mid-load cannot commit a write.
  assign w_mem_we    = ~rst & (w_in_clear | w_load_wr);
  assign w_mem_waddr = w_in_clear ? r_clr_cnt : load_addr;
  assign w_mem_wdata = w_in_clear ? NOP_WORD  : load_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // ------------------------------------------------------------
  // Optional parity storage
  // ------------------------------------------------------------
  logic w_f_par_bad;

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_flip_pend;
  logic w_flip;
  logic w_wr_par;

  // A flip request waits for the next accepted load write.
  assign w_flip   = force_par_flip | r_flip_pend;
  assign w_wr_par = (^w_mem_wdata) ^ (w_load_wr & w_flip);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_waddr] <= w_wr_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flip_pend <= 1'b0;
    end else if (w_load_wr) begin
      r_flip_pend <= 1'b0;
    end else if (force_par_flip) begin
      r_flip_pend <= 1'b1;
    end
  end
`endif

  // ------------------------------------------------------------
  // Fetch decode
  // ------------------------------------------------------------
  logic [AW-1:0]   w_f_idx;
  logic            w_f_mis;
  logic            w_f_oor;
  logic [XLEN-1:0] w_f_rdata;
  logic [1:0]      w_f_cause;
  logic            w_f_fault;
  logic            w_f_fire;

  assign w_f_idx   = fetch_addr[AW+1:2];
  assign w_f_mis   = |fetch_addr[1:0];
  assign w_f_oor   = |fetch_addr[31:AW+2];
  assign w_f_rdata = r_mem[w_f_idx];

`ifdef IMEM_PARITY_EN
  assign w_f_par_bad = (^w_f_rdata) != r_par[w_f_idx];
`else
  assign w_f_par_bad = 1'b0;
`endif

  // Alignment beats range beats parity.
  always_comb begin
    w_f_cause = C_NONE;
    if (w_f_mis) begin
      w_f_cause = C_MIS;
    end else if (w_f_oor) begin
      w_f_cause = C_OOR;
    end else if (w_f_par_bad) begin
      w_f_cause = C_PAR;
    end
  end

  assign w_f_fault = (w_f_cause != C_NONE);
  assign w_f_fire  = w_in_run & fetch_req;

  // ------------------------------------------------------------
  // Next state
  // ------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CLEAR: if (w_clr_last) w_state_nxt = S_LOAD;
      S_LOAD:  if (load_done)  w_state_nxt = S_RUN;
      S_RUN:   if (load_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // ------------------------------------------------------------
  // Control and response registers
  // ------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_CLEAR;
      r_clr_cnt     <= '0;
      r_load_err    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fault_cause <= C_NONE;
      r_instr       <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_in_clear) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end

      if (w_in_load & load_valid & w_load_oob) begin
        r_load_err <= 1'b1;
      end

      // The response registers only carry meaning while
      // fetch_valid is high; instruction_out holds otherwise.
      if (w_f_fire) begin
        r_fetch_valid <= 1'b1;
        r_fetch_fault <= w_f_fault;
        r_fault_cause <= w_f_cause;
        r_instr       <= w_f_fault ? NOP_WORD : w_f_rdata;
      end else begin
        r_fetch_valid <= 1'b0;
        r_fetch_fault <= 1'b0;
        r_fault_cause <= C_NONE;
      end
    end
  end

  // ------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------
  assign load_ready      = w_in_load;
  assign mem_ready       = w_in_run;
  assign load_err        = r_load_err;
  assign fetch_valid     = r_fetch_valid;
  assign fetch_fault     = r_fetch_fault;
  assign fault_cause     = r_fault_cause;
  assign instruction_out = r_instr;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed load/fetch/fault/reset vectors
// checked against a word-array model and a queue of expected responses.
module tb_imem_loadable;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_par_flip = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_done = 1'b0;
  logic        load_err;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [31:0] instruction_out;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        mem_ready;

  always #5 clk = ~clk;

  imem_loadable dut (
    .clk             (clk),
    .rst             (rst),
`ifdef IMEM_PARITY_EN
    .force_par_flip  (force_par_flip),
`endif
    .load_start      (load_start),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done),
    .load_err        (load_err),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_valid     (fetch_valid),
    .instruction_out (instruction_out),
    .fetch_fault     (fetch_fault),
    .fault_cause     (fault_cause),
    .mem_ready       (mem_ready)
  );

  typedef struct {
    int          due;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [DEPTH];
  bit          pb [DEPTH];
  bit          run_m;
  int          cyc;
  bit          rst_at_edge;
  logic [31:0] last_instr;
  int          checks;
  int          errors;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Expected response from the memory image and address rules.
  function automatic exp_t model(logic [31:0] a);
    exp_t e;
    e.due = 0;
    e.fault = 1'b1;
    e.data = NOP;
    if (a % 4 != 0)             e.cause = 2'b01;
    else if (a >= DEPTH * 4)    e.cause = 2'b10;
    else if (pb[a / 4])         e.cause = 2'b11;
    else begin
      e.fault = 1'b0;
      e.cause = 2'b00;
      e.data  = mm[a / 4];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      q.delete();
      last_instr = '0;
      check("rst_valid", 32'(fetch_valid), 0);
      check("rst_instr", instruction_out, 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("rsp_valid", 32'(fetch_valid), 1);
      check("rsp_fault", 32'(fetch_fault), 32'(e.fault));
      check("rsp_cause", 32'(fault_cause), 32'(e.cause));
      check("rsp_instr", instruction_out, e.data);
      last_instr = e.data;
    end else begin
      check("idle_valid", 32'(fetch_valid), 0);
      check("hold_instr", instruction_out, last_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(logic [31:0] a);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    if (run_m) begin
      e = model(a);
      e.due = cyc + 1;
      q.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic load_w(int idx, logic [31:0] d, bit done, bit flip);
    load_valid     = 1'b1;
    load_addr      = 6'(idx);
    load_data      = d;
    load_done      = done;
    force_par_flip = flip;
    mm[idx] = d;
`ifdef IMEM_PARITY_EN
    pb[idx] = flip;
`endif
    tick();
    load_valid     = 1'b0;
    load_done      = 1'b0;
    force_par_flip = 1'b0;
    if (done) run_m = 1;
  endtask

  task automatic done_only();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    run_m = 1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    run_m = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = NOP;
      pb[i] = 0;
    end
    run_m = 0;
  endtask

  // Called right after rst drops: 64 cycles not ready, then LOAD.
  task automatic clear_wait();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_load_ready", 32'(load_ready), 0);
      check("clr_mem_ready", 32'(mem_ready), 0);
      tick();
    end
    @(negedge clk);
    check("clr_done_ready", 32'(load_ready), 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_instr = '0;
    model_reset();

    // Reset and clear
    repeat (2) @(posedge clk);
    #1;
    check("r_load_ready", 32'(load_ready), 0);
    check("r_mem_ready", 32'(mem_ready), 0);
    check("r_load_err", 32'(load_err), 0);
    check("r_fetch_valid", 32'(fetch_valid), 0);
    check("r_fetch_fault", 32'(fetch_fault), 0);
    check("r_fault_cause", 32'(fault_cause), 0);
    check("r_instr", instruction_out, 0);
    rst = 1'b0;
    clear_wait();

    // Fetch in LOAD is ignored
    fetch(32'h0);
    idle();
    done_only();
    check("run_mem_ready", 32'(mem_ready), 1);
    check("run_load_ready", 32'(load_ready), 0);
    fetch(32'h0C);
    check("nop_after_clear", instruction_out, NOP);
    idle();

    // Load and fetch
    start_load();
    check("reload_ready", 32'(load_ready), 1);
    load_w(0, 32'h00500093, 0, 0);
    load_w(5, 32'h11111111, 0, 0);
    load_w(5, 32'h00A18193, 0, 0);
    done_only();
    fetch(32'h00);
    check("lit_w0", instruction_out, 32'h00500093);
    check("lit_w0_v", 32'(fetch_valid), 1);
    fetch(32'h14);
    check("lit_w5", instruction_out, 32'h00A18193);
    fetch(32'h04);
    check("lit_w1_nop", instruction_out, NOP);
    idle();

    // Faults
    fetch(32'h06);
    check("lit_mis_cause", 32'(fault_cause), 1);
    check("lit_mis_instr", instruction_out, NOP);
    fetch(32'h100);
    check("lit_oor_cause", 32'(fault_cause), 2);
    check("lit_oor_fault", 32'(fetch_fault), 1);
    fetch(32'h102);
    check("lit_both_cause", 32'(fault_cause), 1);
    check("lit_both_valid", 32'(fetch_valid), 1);
    fetch(32'h8000_0000);
    fetch(32'hFC);
    idle();

    // Simultaneous events
    start_load();
    load_w(3, 32'hDEADBEEF, 1, 0);
    fetch(32'h0C);
    check("lit_deadbeef", instruction_out, 32'hDEADBEEF);
    load_start = 1'b1;
    fetch(32'h14);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    run_m = 0;
    check("ls_fetch_valid", 32'(fetch_valid), 1);
    check("ls_fetch_instr", instruction_out, 32'h00A18193);
    check("ls_load_ready", 32'(load_ready), 1);
    tick();
    done_only();
    fetch(32'h14);
    fetch(32'h0C);
    fetch(32'h00);
    check("kept_w0", instruction_out, 32'h00500093);
    idle();

`ifdef IMEM_PARITY_EN
    start_load();
    load_w(2, 32'h00200113, 0, 1);
    load_w(4, 32'h00400213, 0, 0);
    done_only();
    fetch(32'h08);
    check("lit_par_fault", 32'(fetch_fault), 1);
    check("lit_par_cause", 32'(fault_cause), 3);
    check("lit_par_instr", instruction_out, NOP);
    fetch(32'h10);
    check("lit_par_ok", instruction_out, 32'h00400213);
    idle();
`endif

    check("load_err", 32'(load_err), 0);

    // Reset mid-operation
    fetch(32'h00);
    fetch(32'h04);
    rst        = 1'b1;
    fetch_addr = 32'h08;
    tick();
    fetch_req = 1'b0;
    model_reset();
    check("mid_rst_valid", 32'(fetch_valid), 0);
    check("mid_rst_instr", instruction_out, 0);
    rst = 1'b0;
    clear_wait();
    done_only();
    for (int i = 0; i < DEPTH; i++) begin
      fetch(32'(i * 4));
    end
    check("post_rst_w3", instruction_out, NOP);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
